// File: rtl/multicycle_ctrl.sv
// Sequencing controller for the multicycle RV32I core: walks each instruction
// through FETCH/DECODE/EXEC/MEM/WB, drives datapath strobes and counts retirements.
module multicycle_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [31:0]      instr,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  input  logic             branch_taken,
  output logic             imem_req,
  output logic             ir_write,
  output logic [2:0]       imm_sel,
  output logic             alu_src_imm,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             reg_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             trap,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    C_R, C_IALU, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC, C_ILL
  } cls_t;

  localparam logic [2:0] IMM_I    = 3'd0;
  localparam logic [2:0] IMM_S    = 3'd1;
  localparam logic [2:0] IMM_B    = 3'd2;
  localparam logic [2:0] IMM_U    = 3'd3;
  localparam logic [2:0] IMM_J    = 3'd4;
  localparam logic [2:0] IMM_NONE = 3'd7;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_REL   = 2'd1;
  localparam logic [1:0] PC_REG   = 2'd2;

  state_t     state, state_n;
  cls_t       cls;
  logic [2:0] fmt;
  logic       unused_instr;

  // Only the major opcode steers sequencing; the rest of the IR belongs to the datapath.
  assign unused_instr = ^instr[31:7];

  // Opcode class and immediate format
  always_comb begin
    cls = C_ILL;
    fmt = IMM_NONE;
    case (instr[6:0])
      7'b0110011: begin cls = C_R;      fmt = IMM_NONE; end
      7'b0010011: begin cls = C_IALU;   fmt = IMM_I;    end
      7'b0000011: begin cls = C_LOAD;   fmt = IMM_I;    end
      7'b0100011: begin cls = C_STORE;  fmt = IMM_S;    end
      7'b1100011: begin cls = C_BRANCH; fmt = IMM_B;    end
      7'b1101111: begin cls = C_JAL;    fmt = IMM_J;    end
      7'b1100111: begin cls = C_JALR;   fmt = IMM_I;    end
      7'b0110111: begin cls = C_LUI;    fmt = IMM_U;    end
      7'b0010111: begin cls = C_AUIPC;  fmt = IMM_U;    end
      default:    begin cls = C_ILL;    fmt = IMM_NONE; end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state; TRAP is absorbing until reset
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   state_n = S_FETCH;
      S_FETCH:  if (imem_ack) state_n = S_DECODE;
      S_DECODE: state_n = (cls == C_ILL) ? S_TRAP : S_EXEC;
      S_EXEC: begin
        if (cls == C_BRANCH)                         state_n = S_FETCH;
        else if (cls == C_LOAD || cls == C_STORE)    state_n = S_MEM;
        else                                         state_n = S_WB;
      end
      S_MEM:    if (dmem_ack) state_n = (cls == C_STORE) ? S_FETCH : S_WB;
      S_WB:     state_n = S_FETCH;
      S_TRAP:   state_n = S_TRAP;
      default:  state_n = S_IDLE;
    endcase
  end

  // Strobes decoded from state and IR; ack/branch inputs only gate same-cycle completion
  always_comb begin
    imem_req    = 1'b0;
    ir_write    = 1'b0;
    imm_sel     = IMM_NONE;
    alu_src_imm = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    reg_write   = 1'b0;
    pc_write    = 1'b0;
    pc_src      = PC_PLUS4;
    trap        = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_write = imem_ack;
      end
      S_DECODE: imm_sel = fmt;
      S_EXEC: begin
        imm_sel     = fmt;
        alu_src_imm = (cls != C_R) && (cls != C_BRANCH);
        if (cls == C_BRANCH) begin
          pc_write = 1'b1;
          pc_src   = branch_taken ? PC_REL : PC_PLUS4;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls == C_STORE);
        pc_write = dmem_ack && (cls == C_STORE);
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        if (cls == C_JAL)       pc_src = PC_REL;
        else if (cls == C_JALR) pc_src = PC_REG;
        else                    pc_src = PC_PLUS4;
      end
      S_TRAP:  trap = 1'b1;
      default: ;
    endcase
  end

  // Every instruction pulses pc_write exactly once, so that marks retirement
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)        instret <= '0;
    else if (pc_write) instret <= instret + CNT_W'(1);
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: a per-instruction phase model predicts
// every output each cycle; a single negedge process compares DUT against it.
module tb_multicycle_ctrl;

  localparam int unsigned CNT_W = 4;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic       imem_req;
    logic       ir_write;
    logic [2:0] imm_sel;
    logic       alu_src_imm;
    logic       dmem_req;
    logic       dmem_we;
    logic       reg_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       trap;
  } exp_t;

  logic             clk = 1'b0;
  logic             n_rst;
  logic [31:0]      instr;
  logic             imem_ack, dmem_ack, branch_taken;
  logic             imem_req, ir_write, alu_src_imm, dmem_req, dmem_we;
  logic             reg_write, pc_write, trap;
  logic [2:0]       imm_sel;
  logic [1:0]       pc_src;
  logic [CNT_W-1:0] instret;

  exp_t             exp_v, act;
  logic [CNT_W-1:0] model_cnt;
  logic             chk_en = 1'b0;
  int               checks = 0;
  int               errors = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .n_rst(n_rst), .instr(instr), .imem_ack(imem_ack),
    .dmem_ack(dmem_ack), .branch_taken(branch_taken), .imem_req(imem_req),
    .ir_write(ir_write), .imm_sel(imm_sel), .alu_src_imm(alu_src_imm),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_write(reg_write),
    .pc_write(pc_write), .pc_src(pc_src), .trap(trap), .instret(instret)
  );

  assign act = {imem_req, ir_write, imm_sel, alu_src_imm, dmem_req, dmem_we,
                reg_write, pc_write, pc_src, trap};

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, a, e, $time);
    end
  endtask

  // Outputs and counter against the model, mid-cycle
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (act !== exp_v) begin
        errors++;
        $display("FAIL outputs: got %b expected %b (req,irw,imm,alu,dreq,dwe,rw,pcw,pcs,trap) at %0t",
                 act, exp_v, $time);
      end
      chk("instret", 32'(instret), 32'(model_cnt));
    end
  end

  function automatic exp_t quiet();
    exp_t e;
    e = '0;
    e.imm_sel = 3'd7;
    return e;
  endfunction

  function automatic logic [2:0] fmt_of(input logic [6:0] op);
    case (op)
      OP_IALU, OP_LOAD, OP_JALR: return 3'd0;
      OP_STORE:                  return 3'd1;
      OP_BRANCH:                 return 3'd2;
      OP_LUI, OP_AUIPC:          return 3'd3;
      OP_JAL:                    return 3'd4;
      default:                   return 3'd7;
    endcase
  endfunction

  function automatic bit legal(input logic [6:0] op);
    return op inside {OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH,
                      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
  endfunction

  // One cycle with expectation e; the model retires on the edge closing a pc_write cycle
  task automatic step(input exp_t e);
    exp_v = e;
    @(posedge clk);
    if (e.pc_write && n_rst) model_cnt = model_cnt + CNT_W'(1);
    #1;
  endtask

  // Stray acks and branch results that the controller must ignore
  task automatic noise();
    imem_ack     = 1'($urandom);
    dmem_ack     = 1'($urandom);
    branch_taken = 1'($urandom);
  endtask

  task automatic run_instr(input logic [31:0] w, input int iw, input int dw, input logic bt,
                           input bit rst_in_mem, output int ncyc);
    exp_t       e;
    logic [6:0] op;
    int         c;
    op = w[6:0];
    c  = 0;
    ncyc = 0;
    for (int i = 0; i < iw; i++) begin
      noise(); imem_ack = 1'b0;
      e = quiet(); e.imem_req = 1'b1;
      step(e); c++;
    end
    noise(); imem_ack = 1'b1;
    e = quiet(); e.imem_req = 1'b1; e.ir_write = 1'b1;
    step(e); c++;
    instr = w;
    noise();
    e = quiet(); e.imm_sel = fmt_of(op);
    step(e); c++;
    if (!legal(op)) begin
      for (int i = 0; i < 20; i++) begin
        noise();
        e = quiet(); e.trap = 1'b1;
        step(e); c++;
      end
      ncyc = c;
      return;
    end
    noise(); branch_taken = bt;
    e = quiet(); e.imm_sel = fmt_of(op);
    e.alu_src_imm = !(op == OP_R || op == OP_BRANCH);
    if (op == OP_BRANCH) begin
      e.pc_write = 1'b1;
      e.pc_src   = {1'b0, bt};
    end
    step(e); c++;
    if (op == OP_BRANCH) begin ncyc = c; return; end
    if (op == OP_LOAD || op == OP_STORE) begin
      for (int i = 0; i < dw; i++) begin
        noise(); dmem_ack = 1'b0;
        e = quiet(); e.dmem_req = 1'b1; e.dmem_we = (op == OP_STORE);
        step(e); c++;
        if (rst_in_mem) begin
          exp_v     = quiet();
          model_cnt = '0;
          n_rst     = 1'b0;
          #1;
          chk("async_dmem_req", 32'(dmem_req), 32'd0);
          chk("async_pc_write", 32'(pc_write), 32'd0);
          chk("async_instret", 32'(instret), 32'd0);
          ncyc = c;
          return;
        end
      end
      noise(); dmem_ack = 1'b1;
      e = quiet(); e.dmem_req = 1'b1; e.dmem_we = (op == OP_STORE);
      e.pc_write = (op == OP_STORE);
      step(e); c++;
      if (op == OP_STORE) begin ncyc = c; return; end
    end
    noise();
    e = quiet(); e.reg_write = 1'b1; e.pc_write = 1'b1;
    e.pc_src = (op == OP_JAL) ? 2'd1 : (op == OP_JALR) ? 2'd2 : 2'd0;
    step(e); c++;
    ncyc = c;
  endtask

  task automatic do_reset(input int n);
    exp_v     = quiet();
    model_cnt = '0;
    n_rst     = 1'b0;
    repeat (n) step(quiet());
    n_rst    = 1'b1;
    imem_ack = 1'b1;
    step(quiet());
  endtask

  logic [6:0] ops [9] = '{OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH,
                          OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

  initial begin
    int n;
    n_rst = 1'b0; instr = '0; imem_ack = 1'b0; dmem_ack = 1'b0; branch_taken = 1'b0;
    model_cnt = '0;
    exp_v = quiet();
    #1 chk_en = 1'b1;

    do_reset(3);
    run_instr(32'h0020A023, 0, 2, 1'b0, 1'b1, n);
    do_reset(2);

    run_instr(32'h00500093, 0, 0, 1'b0, 1'b0, n);
    chk("addi_cycles", 32'(n), 32'd4);
    chk("addi_instret", 32'(instret), 32'd1);
    run_instr(32'h0000A103, 0, 3, 1'b0, 1'b0, n);
    chk("lw_cycles", 32'(n), 32'd8);
    chk("lw_instret", 32'(instret), 32'd2);
    run_instr(32'h00208463, 0, 0, 1'b1, 1'b0, n);
    chk("beq_t_cycles", 32'(n), 32'd3);
    run_instr(32'h00208463, 0, 0, 1'b0, 1'b0, n);
    chk("beq_nt_cycles", 32'(n), 32'd3);
    chk("beq_instret", 32'(instret), 32'd4);
    run_instr(32'h0020A023, 0, 0, 1'b0, 1'b0, n);
    chk("sw_cycles", 32'(n), 32'd4);
    chk("sw_instret", 32'(instret), 32'd5);

    for (int k = 0; k < 60; k++) begin
      logic [31:0] w;
      w = {25'($urandom), ops[$urandom_range(0, 8)]};
      run_instr(w, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom), 1'b0, n);
    end

    run_instr(32'hFFFFFFFF, 1, 0, 1'b0, 1'b0, n);
    chk("trap_cycles", 32'(n), 32'd23);
    chk("trap_sticky", 32'(trap), 32'd1);
    do_reset(2);
    chk("trap_cleared", 32'(trap), 32'd0);

    for (int k = 0; k < 16; k++) run_instr(32'h00500093, 0, 0, 1'b0, 1'b0, n);
    chk("instret_wrap", 32'(instret), 32'd0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
